// File: rtl/register_file.sv
// register_file: one synchronous write port, two independent combinational read ports.
// Latency: a write lands at the rising clk edge, and reads are combinational (0 cycles).
// Backpressure: none; every enabled write completes in one cycle. rst clears all registers asynchronously.
module register_file #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter bit ZERO_REG      = 1'b1,
  parameter bit WRITE_BYPASS  = 1'b0,
  localparam int AW           = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [AW-1:0]         reg_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [AW-1:0]         reg_rd0,
  input  logic [AW-1:0]         reg_rd1,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1
);

  localparam int AWP = AW + 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGISTERS];

  // Extra top bit keeps the compare exact when NUM_REGISTERS is a power of two.
  logic wr_in_range, rd0_in_range, rd1_in_range;
  assign wr_in_range  = {1'b0, reg_wr}  < AWP'(NUM_REGISTERS);
  assign rd0_in_range = {1'b0, reg_rd0} < AWP'(NUM_REGISTERS);
  assign rd1_in_range = {1'b0, reg_rd1} < AWP'(NUM_REGISTERS);

  // Hardwired x0 only when ZERO_REG is set.
  logic wr_is_x0, rd0_is_x0, rd1_is_x0;
  assign wr_is_x0  = ZERO_REG && (reg_wr  == '0);
  assign rd0_is_x0 = ZERO_REG && (reg_rd0 == '0);
  assign rd1_is_x0 = ZERO_REG && (reg_rd1 == '0);

  // A write is effective only outside reset, in range and not to hardwired x0.
  // The same qualifier gates bypass, so discarded writes are never forwarded.
  logic wr_en;
  assign wr_en = write && !rst && wr_in_range && !wr_is_x0;

  // Storage: async clear, then one register updated per enabled write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[reg_wr] <= data_in;
    end
  end

  // Read port 0: bypassed write data, stored value, or zero for x0/out-of-range.
  always_comb begin
    data_out0 = '0;
    if (WRITE_BYPASS && wr_en && (reg_rd0 == reg_wr)) begin
      data_out0 = data_in;
    end else if (rd0_in_range && !rd0_is_x0) begin
      data_out0 = regs[reg_rd0];
    end
  end

  // Read port 1: same selection as port 0, fully independent index.
  always_comb begin
    data_out1 = '0;
    if (WRITE_BYPASS && wr_en && (reg_rd1 == reg_wr)) begin
      data_out1 = data_in;
    end else if (rd1_in_range && !rd1_is_x0) begin
      data_out1 = regs[reg_rd1];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: three register_file variants driven from shared inputs.
// a: defaults (x0 hardwired, no bypass); b: plain r0 with bypass; c: 20 regs, x0, bypass.
// A behavioural model is compared on every negedge; directed literals pin it.
`timescale 1ns/1ps
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [4:0]  reg_wr;
  logic [31:0] data_in;
  logic [4:0]  reg_rd0;
  logic [4:0]  reg_rd1;
  logic [31:0] d0_a, d1_a, d0_b, d1_b, d0_c, d1_c;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  register_file dut_a (
    .clk(clk), .rst(rst), .write(write), .reg_wr(reg_wr), .data_in(data_in),
    .reg_rd0(reg_rd0), .reg_rd1(reg_rd1), .data_out0(d0_a), .data_out1(d1_a)
  );

  register_file #(.ZERO_REG(1'b0), .WRITE_BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .write(write), .reg_wr(reg_wr), .data_in(data_in),
    .reg_rd0(reg_rd0), .reg_rd1(reg_rd1), .data_out0(d0_b), .data_out1(d1_b)
  );

  register_file #(.NUM_REGISTERS(20), .ZERO_REG(1'b1), .WRITE_BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .write(write), .reg_wr(reg_wr), .data_in(data_in),
    .reg_rd0(reg_rd0), .reg_rd1(reg_rd1), .data_out0(d0_c), .data_out1(d1_c)
  );

  // ---------------- behavioural model ----------------
  int          nregs [3] = '{32, 32, 20};
  bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
  bit          byp   [3] = '{1'b0, 1'b1, 1'b1};
  logic [31:0] mem   [3][32];

  function automatic bit writable(input int k, input logic [4:0] idx);
    return !(zr[k] && idx == 5'd0) && (int'(idx) < nregs[k]);
  endfunction

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] idx);
    if (zr[k] && idx == 5'd0) return 32'h0;
    if (int'(idx) >= nregs[k]) return 32'h0;
    if (byp[k] && write && !rst && idx == reg_wr && writable(k, reg_wr)) return data_in;
    return mem[k][idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 32; i++) mem[k][i] = 32'h0;
    end else if (write) begin
      for (int k = 0; k < 3; k++)
        if (writable(k, reg_wr)) mem[k][reg_wr] = data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all six outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model a.out0", d0_a, exp_rd(0, reg_rd0));
      chk("model a.out1", d1_a, exp_rd(0, reg_rd1));
      chk("model b.out0", d0_b, exp_rd(1, reg_rd0));
      chk("model b.out1", d1_b, exp_rd(1, reg_rd1));
      chk("model c.out0", d0_c, exp_rd(2, reg_rd0));
      chk("model c.out1", d1_c, exp_rd(2, reg_rd1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
    write   = 1'b1;
    reg_wr  = idx;
    data_in = val;
    @(posedge clk);
    #1;
    write   = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " a0"}, d0_a, 32'h0);
    chk({name, " a1"}, d1_a, 32'h0);
    chk({name, " b0"}, d0_b, 32'h0);
    chk({name, " b1"}, d1_b, 32'h0);
    chk({name, " c0"}, d0_c, 32'h0);
    chk({name, " c1"}, d1_c, 32'h0);
  endtask

  // ---------------- directed + soak stimulus ----------------
  initial begin
    rst = 1'b1; write = 1'b0; reg_wr = '0; data_in = '0; reg_rd0 = '0; reg_rd1 = '0;
    #12;
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk_all_zero("reset_state");

    // Reset clears arbitrary data, held for two cycles, then sweep all indices.
    @(posedge clk); #1;
    do_write(5'd3, 32'hCAFE0003);
    do_write(5'd31, 32'hCAFE001F);
    do_write(5'd19, 32'hCAFE0013);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      reg_rd0 = 5'(i);
      reg_rd1 = 5'(31 - i);
      #1;
      chk_all_zero("reset_sweep");
    end
    @(posedge clk); #1;

    // Basic write then read on both ports.
    do_write(5'd1, 32'hDEADBEEF);
    do_write(5'd2, 32'h12345678);
    reg_rd0 = 5'd1; reg_rd1 = 5'd2;
    #2;
    chk("basic a0", d0_a, 32'hDEADBEEF);
    chk("basic a1", d1_a, 32'h12345678);
    chk("basic c0", d0_c, 32'hDEADBEEF);
    reg_rd1 = 5'd1;
    #1;
    chk("same_idx a1", d1_a, 32'hDEADBEEF);

    // x0: discarded when hardwired, stored when ordinary.
    do_write(5'd0, 32'hA5A5A5A5);
    reg_rd0 = 5'd0; reg_rd1 = 5'd0;
    #2;
    chk("x0 a0", d0_a, 32'h0);
    chk("x0 a1", d1_a, 32'h0);
    chk("x0 plain b0", d0_b, 32'hA5A5A5A5);
    chk("x0 plain b1", d1_b, 32'hA5A5A5A5);

    // Write enable low leaves r5 alone.
    do_write(5'd5, 32'h00000055);
    write = 1'b0; reg_wr = 5'd5; data_in = 32'hFFFFFFFF;
    @(posedge clk); #1;
    reg_rd0 = 5'd5;
    #2;
    chk("wr_en_low a0", d0_a, 32'h00000055);

    // Same-cycle read/write of r7: old before edge without bypass, new with bypass.
    do_write(5'd7, 32'h00000011);
    reg_rd0 = 5'd7; reg_rd1 = 5'd7;
    write = 1'b1; reg_wr = 5'd7; data_in = 32'h00000022;
    #2;
    chk("rw_same nobyp a0", d0_a, 32'h00000011);
    chk("rw_same byp b0", d0_b, 32'h00000022);
    chk("rw_same byp c1", d1_c, 32'h00000022);
    @(posedge clk); #1;
    write = 1'b0;
    #1;
    chk("rw_after a0", d0_a, 32'h00000022);

    // Out-of-range index on the 20-entry variant: no store, no bypass.
    reg_rd0 = 5'd25;
    write = 1'b1; reg_wr = 5'd25; data_in = 32'hCAFEF00D;
    #2;
    chk("oor_bypass c0", d0_c, 32'h0);
    chk("oor_bypass b0", d0_b, 32'hCAFEF00D);
    @(posedge clk); #1;
    write = 1'b0;
    #1;
    chk("oor_read c0", d0_c, 32'h0);
    chk("oor_read a0", d0_a, 32'hCAFEF00D);

    // Bypass never forwards a write to hardwired x0.
    reg_rd0 = 5'd0;
    write = 1'b1; reg_wr = 5'd0; data_in = 32'h5A5A5A5A;
    #2;
    chk("x0_bypass c0", d0_c, 32'h0);
    chk("x0_bypass b0", d0_b, 32'h5A5A5A5A);
    @(posedge clk); #1;
    write = 1'b0;

    // Back-to-back writes: last one wins.
    do_write(5'd9, 32'h00000001);
    do_write(5'd9, 32'h00000002);
    reg_rd1 = 5'd9;
    #2;
    chk("b2b a1", d1_a, 32'h00000002);

    // Reset raised before the edge of a pending write: write lost.
    do_write(5'd4, 32'h00000044);
    write = 1'b1; reg_wr = 5'd4; data_in = 32'h00000077;
    reg_rd0 = 5'd4;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async a0", d0_a, 32'h0);
    chk("rst_async b0", d0_b, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; write = 1'b0;
    #1;
    chk("rst_midwrite a0", d0_a, 32'h0);
    chk("rst_midwrite c0", d0_c, 32'h0);

    // Random soak with occasional async reset pulses between edges.
    @(posedge clk); #1;
    for (int n = 0; n < 1000; n++) begin
      write   = 1'($urandom_range(0, 1));
      reg_wr  = 5'($urandom_range(0, 31));
      data_in = $urandom();
      reg_rd0 = 5'($urandom_range(0, 31));
      reg_rd1 = ($urandom_range(0, 3) == 0) ? reg_wr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("soak_rst_pulse");
        rst = 1'b0;
      end
      @(posedge clk); #1;
    end

    write = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Multi-ported general-purpose register file for the RISC-V CPU datapath: one synchronous write port and two independent combinational read ports. It sits between decode (which supplies the two source register indices) and writeback (which supplies the destination index and result). Register 0 is optionally hardwired to zero per RISC-V x0 semantics.

## Interface
- DATA_WIDTH, 32, width of each register and of all data ports.
- NUM_REGISTERS, 32, number of registers; must be ≥ 2.
- ZERO_REG, 1, when 1, register 0 always reads zero and ignores writes; when 0, register 0 is an ordinary register.
- WRITE_BYPASS, 0, when 1, a read of the register being written in the same cycle returns data_in combinationally; when 0, it returns the stored (old) value.
- Address width AW = $clog2(NUM_REGISTERS).
- One clock; reset is asynchronous and active-high. Ports are named clk and rst.
- clk  input  1  clock; all writes occur on its rising edge.
- rst  input  1  asynchronous active-high reset; clears every register.
- write  input  1  write enable, sampled at rising clk.
- reg_wr  input  AW  destination register index.
- data_in  input  DATA_WIDTH  write data.
- reg_rd0  input  AW  read port 0 index.
- reg_rd1  input  AW  read port 1 index.
- data_out0  output  DATA_WIDTH  contents of register reg_rd0.
- data_out1  output  DATA_WIDTH  contents of register reg_rd1.

## Operation
- Storage: NUM_REGISTERS × DATA_WIDTH flip-flops.
- Write: at rising clk with write=1 and rst=0, reg[reg_wr] ← data_in. With write=0, no register changes.
- Write to register 0 with ZERO_REG=1 is discarded.
- Write to an index ≥ NUM_REGISTERS (non-power-of-two sizes) is discarded.
- Read: data_outN = reg[reg_rdN], purely combinational, no clock involved. Both ports are fully independent. They may address the same register, and both then return the same value.
- Read of register 0 with ZERO_REG=1 returns 0.
- Read of an index ≥ NUM_REGISTERS returns 0.
- Bypass (WRITE_BYPASS=1): when write=1, reg_rdN == reg_wr, and the target is a writable register, data_outN = data_in in the same cycle. Never bypasses writes to hardwired x0 or out-of-range indices.
- No handshake; every enabled write completes in one cycle.

## Timing
- Reset: rst asserted clears all registers to 0 immediately, without waiting for a clock edge. data_out0 and data_out1 become 0 combinationally. While rst=1, writes are blocked.
- Reset deassertion: the first write takes effect at the first rising clk edge where rst=0 and write=1.
- Write latency: 1 cycle. Data written at edge N is visible on the read ports right after edge N, in the same delta as the register update.
- Read latency: 0 cycles (combinational from reg_rdN and the register state).
- Same-cycle read and write of one index with WRITE_BYPASS=0: the old value is output until the edge, then the new value.
- Back-to-back writes to the same index on consecutive cycles: the last write wins.
- Reset asserted mid-write (rst rising before the clk edge): the write is lost and the register reads 0.

## Test plan
- Reset: hold rst=1 for 2 cycles after writing arbitrary data, then read all 32 indices on both ports. Required: every read returns 0x00000000.
- Basic write/read: write 0xDEADBEEF to r1, then 0x12345678 to r2, then set write=0, reg_rd0=1, reg_rd1=2. Required: data_out0=0xDEADBEEF and data_out1=0x12345678 from the next cycle onward.
- x0 behaviour (ZERO_REG=1): write 0xA5A5A5A5 to r0. Required: reading index 0 on either port returns 0. With ZERO_REG=0, the same write reads back 0xA5A5A5A5.
- Write enable: write=0 with reg_wr=5 and data_in=0xFFFFFFFF, when r5 holds 0x00000055. Required: r5 still reads 0x00000055.
- Same-cycle read/write of r7 (old value 0x11, new value 0x22). Required: with WRITE_BYPASS=0, 0x11 before the edge and 0x22 after; with WRITE_BYPASS=1, 0x22 during the write cycle.
- Random soak: 1000 cycles of random write, indices and data checked against a scoreboard model. Include async rst pulses between clock edges; required: all registers read 0 immediately on each pulse.
